// File: rtl/p2s_pkg.sv
// Shared types and helpers for the round-robin front end of the
// parallel_to_serial serializer.
package p2s_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_t;

  // Index increment that wraps at n rather than at a power of two.
  function automatic int rr_next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: the first set request at or above ptr,
// wrapping past the top. Done as rotate, lowest-bit isolate, un-rotate.
module rr_pick
  import p2s_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   rot_oh;
  logic [2*N_REQ-1:0] unrot;

  // Rotate so the requester at ptr lands on bit 0, then keep its lowest set bit.
  always_comb begin
    rot    = N_REQ'({req, req} >> ptr);
    rot_oh = rot & (~rot + N_REQ'(1));
  end

  // Undo the rotation; the upper half of the doubled vector is the real position.
  always_comb begin
    unrot  = {rot_oh, rot_oh} << ptr;
    onehot = unrot[2*N_REQ-1:N_REQ];
    any    = |req;
  end

  // Encode the one-hot grant into an index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (onehot[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/p2s_rr_arbiter.sv
// Round-robin arbiter sharing one parallel_to_serial serializer between
// N_REQ word producers. A granted word is registered with its source index
// and held on the valid/ready port until the serializer accepts it.
module p2s_rr_arbiter
  import p2s_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 4,
  parameter int IDX_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ-1:0]        req_enable_i,
  output logic                    m_valid_o,
  output logic [DATA_W-1:0]       m_data_o,
  output logic [IDX_W-1:0]        m_src_o,
  input  logic                    m_ready_i,
  output logic                    busy_o
);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic [IDX_W-1:0]  ptr;
  logic [DATA_W-1:0] data_r;
  logic [IDX_W-1:0]  src_r;

  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic [N_REQ-1:0]  pick_oh;
  logic [DATA_W-1:0] pick_data;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req_valid_i & req_enable_i),
    .ptr    (ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  // Select the granted requester's word with an AND-OR mux over the one-hot grant.
  always_comb begin
    pick_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pick_data = pick_data | (req_data_i[k*DATA_W +: DATA_W] & {DATA_W{pick_oh[k]}});
    end
  end

  // Arbitration state register; reset drops any word in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: grant in IDLE whenever anyone is eligible, leave SEND on acceptance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any)  state_d = SEND;
      SEND:    if (m_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the granted word and source; advance the pointer past the accepted source.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r <= '0;
      src_r  <= '0;
      ptr    <= '0;
    end else begin
      if (state_q == IDLE && pick_any) begin
        data_r <= pick_data;
        src_r  <= pick_idx;
      end
      if (state_q == SEND && m_ready_i) begin
        ptr <= IDX_W'(rr_next_idx(int'(src_r), N_REQ));
      end
    end
  end

  // Port outputs; the grant is only offered while idle.
  always_comb begin
    m_valid_o   = (state_q == SEND);
    busy_o      = (state_q == SEND);
    m_data_o    = data_r;
    m_src_o     = src_r;
    req_ready_o = (state_q == IDLE) ? pick_oh : '0;
  end

endmodule

// File: tb/tb_p2s_rr_arbiter.sv
// Bench for p2s_rr_arbiter: table of single-arbitration vectors with a
// scoreboard on the serializer-side handshake, plus back-pressure and
// reset-mid-SEND sequences.
module tb_p2s_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid_i;
  logic [15:0] req_data_i;
  logic [3:0]  req_ready_o;
  logic [3:0]  req_enable_i;
  logic        m_valid_o;
  logic [3:0]  m_data_o;
  logic [1:0]  m_src_o;
  logic        m_ready_i;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  enable;
    logic [15:0] data;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_src;
    logic [3:0]  exp_data;
  } vec_t;

  typedef struct {
    logic [1:0] src;
    logic [3:0] data;
  } exp_t;

  vec_t vecs[15];
  exp_t sb[$];

  p2s_rr_arbiter #(.N_REQ(4), .DATA_W(4), .IDX_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .req_enable_i (req_enable_i),
    .m_valid_o    (m_valid_o),
    .m_data_o     (m_data_o),
    .m_src_o      (m_src_o),
    .m_ready_i    (m_ready_i),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted word must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && m_valid_o && m_ready_i) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got src=%0d data=%0h, expected no word", m_src_o, m_data_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_src", 32'(m_src_o), 32'(e.src));
        check("sb_data", 32'(m_data_o), 32'(e.data));
      end
    end
  end

  initial begin
    // single requester, then all four, wrap with mask, then two-word stream
    vecs[0]  = '{4'b0100, 4'b1111, 16'h4A21, 4'b0100, 2'd2, 4'hA};
    vecs[1]  = '{4'b1111, 4'b1111, 16'h4321, 4'b1000, 2'd3, 4'h4};
    vecs[2]  = '{4'b1111, 4'b1111, 16'h4321, 4'b0001, 2'd0, 4'h1};
    vecs[3]  = '{4'b1111, 4'b1111, 16'h4321, 4'b0010, 2'd1, 4'h2};
    vecs[4]  = '{4'b1111, 4'b1111, 16'h4321, 4'b0100, 2'd2, 4'h3};
    vecs[5]  = '{4'b1111, 4'b1111, 16'h4321, 4'b1000, 2'd3, 4'h4};
    vecs[6]  = '{4'b1111, 4'b1111, 16'h4321, 4'b0001, 2'd0, 4'h1};
    vecs[7]  = '{4'b0010, 4'b1111, 16'h4321, 4'b0010, 2'd1, 4'h2};
    vecs[8]  = '{4'b0100, 4'b1111, 16'h4321, 4'b0100, 2'd2, 4'h3};
    vecs[9]  = '{4'b1001, 4'b0111, 16'h4321, 4'b0001, 2'd0, 4'h1};
    vecs[10] = '{4'b1000, 4'b0111, 16'h4321, 4'b0000, 2'd0, 4'h0};
    vecs[11] = '{4'b0000, 4'b1111, 16'h4321, 4'b0000, 2'd0, 4'h0};
    vecs[12] = '{4'b1000, 4'b1111, 16'h4321, 4'b1000, 2'd3, 4'h4};
    vecs[13] = '{4'b0011, 4'b1111, 16'h006B, 4'b0001, 2'd0, 4'hB};
    vecs[14] = '{4'b0011, 4'b1111, 16'h006B, 4'b0010, 2'd1, 4'h6};

    reset        = 1'b1;
    req_valid_i  = '0;
    req_data_i   = '0;
    req_enable_i = 4'b1111;
    m_ready_i    = 1'b1;
    #3;
    check("rst_m_valid", 32'(m_valid_o), 32'd0);
    check("rst_m_data", 32'(m_data_o), 32'd0);
    check("rst_m_src", 32'(m_src_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_req_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      req_valid_i  = vecs[i].valid;
      req_enable_i = vecs[i].enable;
      req_data_i   = vecs[i].data;
      #1;
      check($sformatf("v%0d_req_ready", i), 32'(req_ready_o), 32'(vecs[i].exp_ready));
      check($sformatf("v%0d_idle", i), 32'(m_valid_o), 32'd0);
      if (vecs[i].exp_ready != 4'b0000) sb.push_back('{vecs[i].exp_src, vecs[i].exp_data});
      @(posedge clk); #1;
      req_valid_i = '0;
      if (vecs[i].exp_ready != 4'b0000) begin
        check($sformatf("v%0d_m_valid", i), 32'(m_valid_o), 32'd1);
        check($sformatf("v%0d_busy", i), 32'(busy_o), 32'd1);
        @(posedge clk); #1;
      end else begin
        check($sformatf("v%0d_no_grant", i), 32'(m_valid_o), 32'd0);
      end
    end
    req_enable_i = 4'b1111;

    // back-pressure: requester 2 granted, serializer stalls 7 cycles
    m_ready_i   = 1'b0;
    req_valid_i = 4'b0100;
    req_data_i  = 16'h0A00;
    #1;
    check("bp_req_ready", 32'(req_ready_o), 32'b0100);
    sb.push_back('{2'd2, 4'hA});
    @(posedge clk); #1;
    req_valid_i = 4'b1111;
    for (int c = 0; c < 7; c++) begin
      check("bp_m_valid", 32'(m_valid_o), 32'd1);
      check("bp_m_data", 32'(m_data_o), 32'hA);
      check("bp_m_src", 32'(m_src_o), 32'd2);
      check("bp_req_ready_low", 32'(req_ready_o), 32'd0);
      @(posedge clk); #1;
    end
    req_valid_i = '0;
    m_ready_i   = 1'b1;
    @(posedge clk); #1;
    check("bp_released", 32'(m_valid_o), 32'd0);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // reset mid-SEND: pointer is 3 here, so requester 0 wins by wrapping
    m_ready_i   = 1'b0;
    req_valid_i = 4'b0001;
    req_data_i  = 16'h0005;
    #1;
    check("rs_req_ready", 32'(req_ready_o), 32'b0001);
    @(posedge clk); #1;
    req_valid_i = '0;
    check("rs_m_valid", 32'(m_valid_o), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rs_async_valid", 32'(m_valid_o), 32'd0);
    check("rs_async_busy", 32'(busy_o), 32'd0);
    check("rs_async_data", 32'(m_data_o), 32'd0);
    check("rs_async_src", 32'(m_src_o), 32'd0);
    @(posedge clk); #1;
    reset       = 1'b0;
    m_ready_i   = 1'b1;
    req_valid_i = 4'b1111;
    req_data_i  = 16'h4321;
    #1;
    check("rs_ptr_zero", 32'(req_ready_o), 32'b0001);
    sb.push_back('{2'd0, 4'h1});
    @(posedge clk); #1;
    req_valid_i = '0;
    check("rs_m_valid_after", 32'(m_valid_o), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
